// File: rtl/usart_pkg.sv
// Shared USART definitions: data width, default Rx FIFO depth, byte type.
package usart_pkg;

    localparam int DATA_W        = 8;
    localparam int RX_FIFO_DEPTH = 8;

    typedef logic [DATA_W-1:0] byte_t;

endpackage

// File: rtl/rx_fifo_mem.sv
// Rx FIFO storage: DEPTH x DATA_W register array, synchronous write,
// combinational read by address. Contents are deliberately not reset.
module rx_fifo_mem
    import usart_pkg::*;
#(
    parameter int DEPTH  = RX_FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_Pclk,
    input  logic              i_We,
    input  logic [ADDR_W-1:0] i_Waddr,
    input  byte_t             i_Wdata,
    input  logic [ADDR_W-1:0] i_Raddr,
    output byte_t             o_Rdata
);

    byte_t mem [DEPTH];

    // Store the incoming byte at the write address when enabled.
    always_ff @(posedge i_Pclk) begin
        if (i_We) begin
            mem[i_Waddr] <= i_Wdata;
        end
    end

    assign o_Rdata = mem[i_Raddr];

endmodule

// File: rtl/rx_fifo.sv
// Rx receive FIFO between the Rx shift register and the APB read path.
// Optional macro RX_FIFO_THRESH_EN adds a registered o_Thresh output
// (count >= THRESH) for the status/interrupt logic.
//
// Handshake: every high cycle of i_Wr_En is one write (no back-pressure;
// a write into a full FIFO is dropped and flagged as overrun). A read is
// the rising edge of the level i_Rd_En; exactly one cycle later o_Pready
// pulses for one cycle with o_Prdata holding the byte (0x00 if the FIFO
// was empty). o_Prdata is 0x00 whenever o_Pready is low.
module rx_fifo
    import usart_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH,
`ifdef RX_FIFO_THRESH_EN
    parameter int THRESH = DEPTH / 2,
`endif
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_Pclk,
    input  logic              i_Preset,
    input  logic              i_Wr_En,
    input  byte_t             i_Wr_Data,
    input  logic              i_Rd_En,
    input  logic              i_Clr_Ovr,
    output byte_t             o_Prdata,
    output logic              o_Pready,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Empty,
    output logic              o_Full,
`ifdef RX_FIFO_THRESH_EN
    output logic              o_Thresh,
`endif
    output logic              o_Overrun
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;
    logic              rd_en_q;
    byte_t             rd_byte;

    logic empty;
    logic full;
    logic pop;
    logic do_pop;
    logic drop;
    logic do_wr;

    assign empty  = (count == '0);
    assign full   = (count == DEPTH_C);
    assign pop    = i_Rd_En & ~rd_en_q;
    assign do_pop = pop & ~empty;
    // A pop in the same cycle frees a slot first, so a full FIFO accepts the write.
    assign drop   = i_Wr_En & full & ~pop;
    assign do_wr  = i_Wr_En & ~drop;

    rx_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_Pclk  (i_Pclk),
        .i_We    (do_wr),
        .i_Waddr (wr_ptr),
        .i_Wdata (i_Wr_Data),
        .i_Raddr (rd_ptr),
        .o_Rdata (rd_byte)
    );

    // Next fill level from the accepted write and the effective pop.
    always_comb begin
        count_next = count;
        case ({do_wr, do_pop})
            2'b10:   count_next = count + (ADDR_W + 1)'(1);
            2'b01:   count_next = count - (ADDR_W + 1)'(1);
            default: count_next = count;
        endcase
    end

    // Pointers, count, read edge detector, read response and overrun flag.
    always_ff @(posedge i_Pclk or posedge i_Preset) begin
        if (i_Preset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_en_q   <= 1'b0;
            o_Prdata  <= '0;
            o_Pready  <= 1'b0;
            o_Overrun <= 1'b0;
        end else begin
            rd_en_q  <= i_Rd_En;
            count    <= count_next;
            o_Pready <= pop;
            o_Prdata <= do_pop ? rd_byte : '0;
            if (do_wr) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (drop) begin
                o_Overrun <= 1'b1;
            end else if (i_Clr_Ovr) begin
                o_Overrun <= 1'b0;
            end
        end
    end

`ifdef RX_FIFO_THRESH_EN
    localparam logic [ADDR_W:0] THRESH_C = (ADDR_W + 1)'(THRESH);

    // Threshold flag tracks the same cycle as o_Count.
    always_ff @(posedge i_Pclk or posedge i_Preset) begin
        if (i_Preset) begin
            o_Thresh <= 1'b0;
        end else begin
            o_Thresh <= (count_next >= THRESH_C);
        end
    end
`endif

    assign o_Count = count;
    assign o_Empty = empty;
    assign o_Full  = full;

endmodule

// File: tb/tb_rx_fifo.sv
// Testbench for rx_fifo (DEPTH = 8). Read responses are checked by a
// negedge monitor against an expected-byte queue; flags are checked inline.
module tb_rx_fifo;
    import usart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       clr_ovr;
    logic [7:0] prdata;
    logic       pready;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       overrun;
`ifdef RX_FIFO_THRESH_EN
    logic       thresh;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt = 0;
    logic [7:0] exp_q[$];

    rx_fifo #(
`ifdef RX_FIFO_THRESH_EN
        .THRESH (4),
`endif
        .DEPTH  (8)
    ) dut (
        .i_Pclk    (clk),
        .i_Preset  (rst),
        .i_Wr_En   (wr_en),
        .i_Wr_Data (wr_data),
        .i_Rd_En   (rd_en),
        .i_Clr_Ovr (clr_ovr),
        .o_Prdata  (prdata),
        .o_Pready  (pready),
        .o_Count   (count),
        .o_Empty   (empty),
        .o_Full    (full),
`ifdef RX_FIFO_THRESH_EN
        .o_Thresh  (thresh),
`endif
        .o_Overrun (overrun)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (pready === 1'b1) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pready: got prdata %0h expected no response", prdata);
            end else begin
                check("prdata", {24'd0, prdata}, {24'd0, exp_q.pop_front()});
            end
        end else begin
            check("prdata_idle", {24'd0, prdata}, 32'd0);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_pop(input logic [7:0] e);
        exp_q.push_back(e);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
    endtask

    task automatic pop_and_write(input logic [7:0] e, input logic [7:0] b);
        exp_q.push_back(e);
        rd_en = 1'b1;
        wr_en = 1'b1;
        wr_data = b;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        tick();
    endtask

    initial begin
        int p0;
        int waited;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        rd_en = 1'b0;
        clr_ovr = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // reset state
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_pready", {31'd0, pready}, 32'd0);

        // pop when empty still answers with 0x00
        read_pop(8'h00);
        check("empty_pop_count", {28'd0, count}, 32'd0);
        check("empty_pop_empty", {31'd0, empty}, 32'd1);

        // two writes, two reads
        write_byte(8'hA5);
        write_byte(8'h3C);
        check("wr2_count", {28'd0, count}, 32'd2);
        read_pop(8'hA5);
        check("rd1_count", {28'd0, count}, 32'd1);
        read_pop(8'h3C);
        check("rd2_count", {28'd0, count}, 32'd0);

        // held read level pops once
        write_byte(8'h01);
        write_byte(8'h02);
        p0 = pulse_cnt;
        exp_q.push_back(8'h01);
        rd_en = 1'b1;
        repeat (5) tick();
        rd_en = 1'b0;
        tick();
        check("hold_pulses", pulse_cnt - p0, 32'd1);
        check("hold_count", {28'd0, count}, 32'd1);
        read_pop(8'h02);

        // overflow: 9 writes into 8 slots
        for (int i = 0; i < 9; i++) write_byte(8'(i));
        check("ovf_full", {31'd0, full}, 32'd1);
        check("ovf_overrun", {31'd0, overrun}, 32'd1);
        check("ovf_count", {28'd0, count}, 32'd8);
        for (int i = 0; i < 8; i++) read_pop(8'(i));
        check("drain_empty", {31'd0, empty}, 32'd1);
        check("drain_overrun", {31'd0, overrun}, 32'd1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("clr_overrun", {31'd0, overrun}, 32'd0);

        // pop and write together while full
        for (int i = 0; i < 8; i++) write_byte(8'h10 + 8'(i));
        pop_and_write(8'h10, 8'hEE);
        check("fullpw_count", {28'd0, count}, 32'd8);
        check("fullpw_overrun", {31'd0, overrun}, 32'd0);
        check("fullpw_full", {31'd0, full}, 32'd1);
        for (int i = 1; i < 8; i++) read_pop(8'h10 + 8'(i));
        read_pop(8'hEE);
        check("fullpw_drain", {28'd0, count}, 32'd0);

        // pop and write together while empty: no fall-through
        pop_and_write(8'h00, 8'h55);
        check("emptypw_count", {28'd0, count}, 32'd1);
        read_pop(8'h55);

`ifdef RX_FIFO_THRESH_EN
        for (int i = 0; i < 3; i++) write_byte(8'h61 + 8'(i));
        check("thresh_3", {31'd0, thresh}, 32'd0);
        write_byte(8'h64);
        check("thresh_4", {31'd0, thresh}, 32'd1);
        read_pop(8'h61);
        check("thresh_rd", {31'd0, thresh}, 32'd0);
        for (int i = 2; i < 5; i++) read_pop(8'h60 + 8'(i));
`endif

        // dropped write coinciding with clear: set wins
        for (int i = 0; i < 8; i++) write_byte(8'h70 + 8'(i));
        wr_en = 1'b1;
        wr_data = 8'h99;
        clr_ovr = 1'b1;
        tick();
        wr_en = 1'b0;
        clr_ovr = 1'b0;
        check("setwins_overrun", {31'd0, overrun}, 32'd1);
        check("setwins_count", {28'd0, count}, 32'd8);

        // reset mid-stream cancels the in-flight read response
        rd_en = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_pready", {31'd0, pready}, 32'd0);
        check("midrst_count", {28'd0, count}, 32'd0);
        check("midrst_empty", {31'd0, empty}, 32'd1);
        check("midrst_full", {31'd0, full}, 32'd0);
        check("midrst_overrun", {31'd0, overrun}, 32'd0);
`ifdef RX_FIFO_THRESH_EN
        check("midrst_thresh", {31'd0, thresh}, 32'd0);
`endif
        rd_en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        read_pop(8'h00);
        check("postrst_count", {28'd0, count}, 32'd0);

        // bounded wait for outstanding responses
        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            tick();
            waited++;
        end
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_fifo.md
Name: rx_fifo

Overview:
Receive buffer between the Rx shift register and the APB read-data path. It captures each completed byte strobed by the Rx shift register into a circular FIFO and returns one byte per APB read, with an o_Pready pulse. It replaces the single-entry Rx data register, so back-to-back frames are not lost while software is slow to read. It also reports fill level and a sticky overrun flag to the status register.

Parameters:
DEPTH, 8, number of byte entries; power of two, minimum 2
ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden
THRESH, DEPTH/2, fill level for the threshold flag (optional feature only); range 1..DEPTH

Ports:
i_Pclk  input  1  APB clock; all state on the rising edge
i_Preset  input  1  asynchronous, active-high reset
i_Wr_En  input  1  write strobe from the Rx shift register (done pulse); each high cycle is one write
i_Wr_Data  input  8  received byte, valid while i_Wr_En is high
i_Rd_En  input  1  read enable from the bus interface; level, held through the APB access
i_Clr_Ovr  input  1  clears the overrun flag; single-cycle strobe from the status register
o_Prdata  output  8  read byte; 0x00 whenever o_Pready is low (OR-combined bus)
o_Pready  output  1  one-cycle read-complete pulse
o_Count  output  ADDR_W+1  current number of stored entries, 0..DEPTH
o_Empty  output  1  o_Count == 0
o_Full  output  1  o_Count == DEPTH
o_Overrun  output  1  sticky; a write was dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync release): write pointer, read pointer and count = 0; o_Prdata = 0x00; o_Pready = 0; o_Overrun = 0; o_Empty = 1; o_Full = 0; i_Rd_En edge register = 0.
- Storage: DEPTH x 8 register array; memory contents are not reset.
- Write, cycle n with i_Wr_En = 1:
  - Not full: store the byte at the write pointer; write pointer +1, wrapping mod DEPTH.
  - Full and no pop this cycle: byte dropped, pointers unchanged, o_Overrun set from n+1.
- Pop: taken on the rising edge of i_Rd_En (i_Rd_En = 1 and the registered copy = 0). A level held for several cycles pops exactly once.
- Pop in cycle n, not empty: o_Prdata = mem[read pointer] and o_Pready = 1 in cycle n+1 only; read pointer +1, wrapping.
- Pop when empty: o_Pready still pulses in n+1 so the bus never stalls; o_Prdata = 0x00; pointers unchanged; no error flag.
- Count transitions (next-cycle):
  - write only: +1
  - pop only: -1
  - both: unchanged
  - dropped write: unchanged
- Simultaneous pop and write:
  - When full: both succeed; the read slot is freed first, so the write is not dropped and overrun is not set.
  - When empty: the pop returns 0x00 and the byte is stored; count = 1. No fall-through.
- Overrun flag: i_Clr_Ovr clears it next cycle. If a clear and a dropped write coincide, set wins.
- Flags: o_Count, o_Empty and o_Full are registered or decoded from registered count; they are valid the cycle after the update.
- Reset asserted mid-operation: immediate return to reset values; an o_Pready pulse in flight is cancelled.

Optional Feature:
RX_FIFO_THRESH_EN
- Defined: adds output o_Thresh (1 bit), registered, = (count >= THRESH), reset 0. Intended for the status register and interrupt logic.
- Undefined: port and logic absent; THRESH is unused.

Decomposition:
- Shared package usart_pkg holds:
  - constant DATA_W = 8
  - the default FIFO depth constant
  - a typedef for the byte type
- One natural sub-module: rx_fifo_mem (DEPTH x DATA_W register array, synchronous write, combinational read by address). Pointers, count and flags stay in rx_fifo.

Test Plan:
- Reset, then pulse i_Rd_En once -> o_Pready = 1 for one cycle, o_Prdata = 0x00, o_Count = 0, o_Empty = 1.
- Write 0xA5, 0x3C, then perform two reads -> o_Prdata = 0xA5 then 0x3C, each with a single o_Pready pulse; o_Count goes 2, 1, 0.
- Hold i_Rd_En high for 5 cycles with 2 entries stored -> exactly one pop (0x01), o_Count = 1.
- Write 9 bytes 0x00..0x08 with DEPTH = 8 -> o_Full = 1, o_Overrun = 1; drain 8 reads returns 0x00..0x07 in order; i_Clr_Ovr -> o_Overrun = 0.
- When full, issue a pop and a write of 0xEE in the same cycle -> pop returns the oldest byte, o_Overrun stays 0, o_Count stays 8; 0xEE is read last after the pointers wrap.
- With RX_FIFO_THRESH_EN and THRESH = 4: after 3 writes o_Thresh = 0, after the 4th write it is 1; one read -> 0. Assert i_Preset mid-stream -> all outputs return to reset values immediately.
